// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// The transmitter and receiver both use these, so the two can be looped back.
package uart_pkg;

    localparam int DEFAULT_CLK_PER_BIT = 434;  // 50 MHz / 115200
    localparam int DATA_BITS           = 8;
    localparam int FRAME_BITS          = DATA_BITS + 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START_BIT = 2'd1,
        S_DATA_BITS = 2'd2,
        S_STOP_BIT  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the transmitter.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, FIFO, serialiser FSM.
// Consecutive queued bytes go out with no idle gap between stop and start bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int            CW       = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLK_PER_BIT - 2);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CW-1:0]        bit_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 period_end;
    logic                 pop;

    assign period_end = (bit_cnt == LAST);
    assign pop        = !fifo_empty &&
                        ((state == S_IDLE) || (state == S_STOP_BIT && period_end));
    assign tx_ready   = !fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // Registered done pulse: armed one cycle early so it lands on the last stop cycle.
            tx_done <= (state == S_STOP_BIT) && (bit_cnt == PRE_LAST);
            bit_cnt <= (state == S_IDLE || period_end) ? '0 : bit_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift     <= fifo_dout;
                        bit_idx   <= '0;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= S_START_BIT;
                    end
                end
                S_START_BIT: begin
                    if (period_end) begin
                        tx_serial <= shift[0];
                        state     <= S_DATA_BITS;
                    end
                end
                S_DATA_BITS: begin
                    if (period_end) begin
                        if (bit_idx == LAST_IDX) begin
                            tx_serial <= 1'b1;
                            state     <= S_STOP_BIT;
                        end else begin
                            tx_serial <= shift[1];
                            shift     <= {1'b0, shift[DATA_BITS-1:1]};
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end
                end
                S_STOP_BIT: begin
                    if (period_end) begin
                        if (pop) begin
                            shift     <= fifo_dout;
                            bit_idx   <= '0;
                            tx_serial <= 1'b0;
                            state     <= S_START_BIT;
                        end else begin
                            tx_busy   <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame table, scoreboard of accepted bytes
// against a cycle-by-cycle line decoder, plus burst, push/pop and reset sequences.
module tb_uart_tx;

    localparam int C     = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 40 * C;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // {stop, d7..d0, start}; bit 0 goes on the line first
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_serial, tx_busy, tx_done;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    vec_t       vecs[6];

    uart_tx #(.CLK_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; holds valid until accepted and leaves valid asserted.
    task automatic push_one(input logic [7:0] b, output int t_seen);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int n = 0; n < TMO && tx_ready !== 1'b1; n++) @(negedge clk);
        t_seen = cyc;
        if (tx_ready !== 1'b1) begin
            check("ready_timeout", tx_ready, 1);
            tx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        sb.push_back(b);
    endtask

    task automatic send_byte(input logic [7:0] b, output int t_acc);
        int ts;
        push_one(b, ts);
        tx_valid = 1'b0;
        tx_data  = ~b;
        t_acc    = cyc;
    endtask

    // Watches every cycle of one frame, then pops the scoreboard and compares.
    task automatic recv_frame(output logic [9:0] bits, output int t_fall);
        bit         stable = 1'b1;
        bit         busy_ok = 1'b1;
        int         done_cnt = 0;
        int         done_at = -1;
        logic [7:0] exp;
        bits   = '0;
        t_fall = -1;
        for (int n = 0; n < TMO && tx_serial !== 1'b0; n++) @(negedge clk);
        if (tx_serial !== 1'b0) begin
            check("frame_timeout", tx_serial, 0);
            return;
        end
        t_fall = cyc;
        for (int j = 0; j < 10 * C; j++) begin
            if (j % C == 0) bits[j / C] = tx_serial;
            else if (tx_serial !== bits[j / C]) stable = 1'b0;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at = j;
            end
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
        end
        check("bit_stable", stable, 1);
        check("busy_in_frame", busy_ok, 1);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_at, 10 * C - 1);
        check("start_stop", {bits[9], bits[0]}, 2'b10);
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("sb_byte", bits[8:1], exp);
        end
    endtask

    initial begin
        logic [9:0] bits;
        int         ta, tf, tf0, tf1, t_rdy, lows;
        logic [7:0] burst[6];

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h55, 10'b1010101010};
        vecs[4] = '{8'hAA, 10'b1101010100};
        vecs[5] = '{8'h3C, 10'b1001111000};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_serial", tx_serial, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames from the table: waveform, latency, return to idle
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].data, ta);
            recv_frame(bits, tf);
            check("latency", tf - ta, 1);
            check("frame_vec", bits, vecs[i].frame);
            check("idle_after", {tx_busy, tx_serial}, 2'b01);
            repeat (3) @(negedge clk);
        end

        // Back-to-back 0x00 then 0xFF: no idle cycle between frames
        send_byte(8'h00, ta);
        send_byte(8'hFF, ta);
        recv_frame(bits, tf0);
        check("b2b_frame0", bits, 10'b1000000000);
        recv_frame(bits, tf1);
        check("b2b_frame1", bits, 10'b1111111110);
        check("b2b_gap", tf1 - tf0, 10 * C);
        check("b2b_idle", {tx_busy, tx_serial}, 2'b01);
        repeat (3) @(negedge clk);

        // Six bytes with valid held: five fit, ready returns at end of first stop bit
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        tf0 = -1;
        fork
            begin
                int ts;
                for (int i = 0; i < 6; i++) begin
                    if (i == 5) check("burst_full", tx_ready, 0);
                    push_one(burst[i], ts);
                    if (i == 5) t_rdy = ts;
                end
                tx_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    recv_frame(bits, tf);
                    if (k == 0) tf0 = tf;
                end
            end
        join
        check("burst_ready_back", t_rdy - tf0, 10 * C);
        repeat (3) @(negedge clk);

        // Push and pop on the same edge with three bytes queued
        fork
            begin
                send_byte(8'hC1, ta);
                send_byte(8'hC2, ta);
                send_byte(8'hC3, ta);
                send_byte(8'hC4, ta);
                for (int n = 0; n < TMO && tx_done !== 1'b1; n++) @(negedge clk);
                check("pp_done_seen", tx_done, 1);
                check("pp_ready_before", tx_ready, 1);
                tx_data  = 8'hC5;
                tx_valid = 1'b1;
                @(negedge clk);
                sb.push_back(8'hC5);
                tx_valid = 1'b0;
                check("pp_ready_after", tx_ready, 1);
                tx_data  = 8'hC6;
                tx_valid = 1'b1;
                @(negedge clk);
                sb.push_back(8'hC6);
                tx_valid = 1'b0;
                check("pp_full_after_one_more", tx_ready, 0);
            end
            begin
                for (int k = 0; k < 6; k++) recv_frame(bits, tf);
            end
        join
        repeat (3) @(negedge clk);

        // Reset in the middle of the data bits of 0x3C, with another byte queued
        send_byte(8'h3C, ta);
        send_byte(8'h99, ta);
        repeat (3 * C + 3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_serial", tx_serial, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_done", tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        lows = 0;
        for (int j = 0; j < 4 * C; j++) begin
            if (tx_serial !== 1'b1) lows++;
            @(negedge clk);
        end
        check("post_rst_quiet", lows, 0);
        send_byte(8'h81, ta);
        recv_frame(bits, tf);
        check("post_rst_latency", tf - ta, 1);
        check("post_rst_frame", bits, 10'b1100000010);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) on a single line. It is the transmit-side counterpart of the team's UART receiver, using the same bit-period convention, so the two can be looped back. It sits between on-chip byte producers and the board TX pin.

## Interface

- CLK_PER_BIT, 434: clock cycles per bit (50 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, at least 2.

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  FIFO not full; byte accepted on any edge with tx_valid && tx_ready.
- tx_serial  output  1  serial line; idles high; registered.
- tx_busy  output  1  high while a frame is on the line (START_BIT..STOP_BIT).
- tx_done  output  1  one-cycle pulse in the final cycle of each stop bit.

## Operation

- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE: tx_serial=1. If FIFO not empty: pop head into 8-bit shift register, bit counter=0, index=0, go to START_BIT, and drive tx_serial=0 on the same edge.
- START_BIT: hold 0 for CLK_PER_BIT cycles; on counter==CLK_PER_BIT-1, counter=0, drive shift[0], go to DATA_BITS.
- DATA_BITS: each bit held CLK_PER_BIT cycles; at period end shift right, index+1; after index 7 completes, drive 1, go to STOP_BIT.
- STOP_BIT: hold 1 for CLK_PER_BIT cycles; tx_done=1 in last cycle. At period end: FIFO not empty → pop, drive 0, go to START_BIT (no idle gap); else go to IDLE.
- Bit counter width = $clog2(CLK_PER_BIT); index 3 bits; FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH.
- tx_ready = !full, derived from occupancy only; a same-cycle pop does not raise it.
- Push and pop in the same cycle: both occur, occupancy unchanged.
- tx_valid with tx_ready low: ignored; producer must hold tx_data/tx_valid.
- tx_data changes after acceptance never affect a queued or in-flight byte.

## Timing

- Reset values: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, FIFO empty, counters 0.
- Reset mid-frame: tx_serial returns high asynchronously, frame truncated, FIFO contents discarded.
- Latency: byte accepted at edge N into empty FIFO while IDLE → tx_serial falls at edge N+1.
- Frame length: exactly 10*CLK_PER_BIT cycles from start-bit falling edge to end of stop bit.
- Back-to-back: next start bit begins on the edge immediately after the last stop-bit cycle.
- tx_busy rises with the start bit, falls on entry to IDLE.

## Structure

- Package uart_pkg: state encoding (2-bit enum), DEFAULT_CLK_PER_BIT=434, frame constants (DATA_BITS=8). Shared with the receiver.
- Sub-module uart_tx_fifo: synchronous FIFO (push/pop/full/empty/data_out, async active-low reset). The top holds the FSM, bit counter and shift register.

## Test plan

- CLK_PER_BIT=8, send 0xA5 → line low 8 cycles, then 1,0,1,0,0,1,0,1 each 8 cycles, high 8 cycles; tx_done pulses once at cycle 80.
- Send 0x00 then 0xFF back-to-back → stop bit of first immediately followed by start bit of second; 160 cycles total, no idle cycle between frames.
- FIFO_DEPTH=4, hold tx_valid for 6 bytes while idle → 5 accepted (1 in flight, 4 queued), tx_ready low until first stop bit ends; all bytes emitted in order.
- Assert rst_n low mid DATA_BITS of 0x3C → tx_serial high immediately, tx_busy=0, tx_ready=1; next byte 0x81 after release transmits cleanly.
- Push and pop same cycle with FIFO at 3/4 → occupancy stays 3, tx_ready stays high.
- Loop tx_serial into the team's UART receiver at CLK_PER_BIT=434, send 0x00, 0x55, 0xAA, 0xFF → receiver reports identical bytes with one finish pulse each.
